// File: rtl/mem_lsu_seq_pkg.sv
// Shared encodings for the MiniMIPS32 multi-cycle load/store unit:
// access sizes, exception codes and the sequencer state type.
package mem_lsu_seq_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_DBE  = 5'h07;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/mem_lsu_seq_lane.sv
// Combinational lane steering: alignment check, byte enables, store
// replication and load extract/extend for one access.
module mem_lsu_lane
   import mem_lsu_seq_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BIG_ENDIAN = 1
)(
   input  logic [1:0]          size,
   input  logic [2:0]          addr_lo,
   input  logic                sign_ext,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W-1:0]   rdata,
   output logic                misaligned,
   output logic [DATA_W/8-1:0] be,
   output logic [DATA_W-1:0]   wdata_rep,
   output logic [DATA_W-1:0]   rdata_ext
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

   function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] v,
                                                     input int nbytes,
                                                     input logic sgn);
      logic [DATA_W-1:0] mask;
      logic [DATA_W-1:0] top;
      logic              msb;
      mask = ~({DATA_W{1'b1}} << (nbytes * 8));
      top  = v >> (nbytes * 8 - 1);
      msb  = sgn & top[0];
      return (v & mask) | (msb ? ~mask : '0);
   endfunction

   int nbytes;
   int off;
   int low;

   always_comb begin
      misaligned = 1'b0;
      case (size)
         SZ_BYTE:  misaligned = 1'b0;
         SZ_HALF:  misaligned = addr_lo[0];
         SZ_WORD:  misaligned = |addr_lo[1:0];
         SZ_DWORD: misaligned = (DATA_W == 32) || (|addr_lo[2:0]);
      endcase
   end

   // The value occupies lanes [low, low+nbytes); in big-endian order the
   // lowest address sits in the highest of those lanes.
   always_comb begin
      nbytes = 1 << size;
      if (nbytes > LANES)
         nbytes = LANES;
      off = int'(addr_lo[OFF_W-1:0]);
      low = (BIG_ENDIAN != 0) ? (LANES - off - nbytes) : off;
      if (misaligned || low < 0)
         low = 0;
   end

   always_comb begin
      logic [DATA_W-1:0] chunk;
      be        = misaligned ? '0 : (~({LANES{1'b1}} << nbytes)) << low;
      chunk     = wdata & ~({DATA_W{1'b1}} << (nbytes * 8));
      wdata_rep = '0;
      for (int k = 0; k < LANES; k++)
         if (k % nbytes == 0)
            wdata_rep = wdata_rep | (chunk << (k * 8));
      rdata_ext = extend_load(rdata >> (low * 8), nbytes, sign_ext);
   end

endmodule

// File: rtl/mem_lsu_seq.sv
// Multi-cycle load/store unit with req/gnt/rvalid data bus and stall.
// Optional bus-wait watchdog enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_lsu_seq
   import mem_lsu_seq_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int BIG_ENDIAN  = 1,
   parameter int TIMEOUT_CYC = 255
)(
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst,
   input  logic                flush_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic                req_store_i,
   input  logic [1:0]          req_size_i,
   input  logic                req_signed_i,
   input  logic [ADDR_W-1:0]   req_addr_i,
   input  logic [DATA_W-1:0]   req_wdata_i,
   output logic                stall_o,
   output logic                dbus_req_o,
   input  logic                dbus_gnt_i,
   output logic                dbus_we_o,
   output logic [DATA_W/8-1:0] dbus_be_o,
   output logic [ADDR_W-1:0]   dbus_addr_o,
   output logic [DATA_W-1:0]   dbus_wdata_o,
   input  logic                dbus_rvalid_i,
   input  logic [DATA_W-1:0]   dbus_rdata_i,
   input  logic                dbus_err_i,
   output logic                resp_valid_o,
   input  logic                resp_ready_i,
   output logic [DATA_W-1:0]   resp_rdata_o,
   output logic                resp_exc_o,
   output logic [4:0]          resp_exccode_o,
   output logic [ADDR_W-1:0]   resp_badvaddr_o
);

   localparam int LANES = DATA_W / 8;
   localparam int OFF_W = $clog2(LANES);

   lsu_state_e state_q, state_d;
   logic       kill_q, kill_d;
   logic       take_req, take_bad, take_beat;
   logic       wd_expired;
   logic       in_idle;

   logic              op_store_p0, op_signed_p0;
   logic [1:0]        op_size_p0;
   logic [ADDR_W-1:0] op_addr_p0;
   logic [DATA_W-1:0] op_wdata_p0;

   logic [DATA_W-1:0] rsp_rdata_p1;
   logic              rsp_exc_p1;
   logic [4:0]        rsp_code_p1;
   logic [ADDR_W-1:0] rsp_bad_p1;

   logic [1:0]        ln_size;
   logic [2:0]        ln_addr_lo;
   logic              ln_misaligned;
   logic [LANES-1:0]  ln_be;
   logic [DATA_W-1:0] ln_wdata_rep, ln_rdata_ext;

   assign in_idle    = (state_q == ST_IDLE);
   // The alignment check looks at the incoming op; everything else at the held op.
   assign ln_size    = in_idle ? req_size_i : op_size_p0;
   assign ln_addr_lo = in_idle ? req_addr_i[2:0] : op_addr_p0[2:0];

   mem_lsu_lane #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane (
      .size       (ln_size),
      .addr_lo    (ln_addr_lo),
      .sign_ext   (op_signed_p0),
      .wdata      (op_wdata_p0),
      .rdata      (dbus_rdata_i),
      .misaligned (ln_misaligned),
      .be         (ln_be),
      .wdata_rep  (ln_wdata_rep),
      .rdata_ext  (ln_rdata_ext)
   );

`ifdef MEM_LSU_TIMEOUT_EN
   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT_CYC);
   logic [7:0] wd_cnt_q;

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst || state_q != ST_WAIT)
         wd_cnt_q <= 8'd0;
      else
         wd_cnt_q <= wd_cnt_q + 8'd1;
   end

   assign wd_expired = (state_q == ST_WAIT) && (wd_cnt_q == WD_LIMIT);
`else
   assign wd_expired = 1'b0;
`endif

   // kill_q remembers a flush seen after grant so the beat completes silently.
   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      take_req  = 1'b0;
      take_bad  = 1'b0;
      take_beat = 1'b0;
      case (state_q)
         ST_IDLE: begin
            kill_d = 1'b0;
            if (req_valid_i && !flush_i) begin
               if (ln_misaligned) begin
                  take_bad = 1'b1;
                  state_d  = ST_RESP;
               end else begin
                  take_req = 1'b1;
                  state_d  = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (dbus_gnt_i) begin
               state_d = ST_WAIT;
               kill_d  = flush_i;
            end else if (flush_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            kill_d = kill_q | flush_i;
            if (dbus_rvalid_i || wd_expired) begin
               if (kill_q || flush_i) begin
                  state_d = ST_IDLE;
               end else begin
                  take_beat = 1'b1;
                  state_d   = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (flush_i || resp_ready_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state_q <= ST_IDLE;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         kill_q  <= kill_d;
      end
   end

   // p0: op captured at accept
   always_ff @(posedge cpu_clk_50M) begin
      if (take_req) begin
         op_store_p0  <= req_store_i;
         op_signed_p0 <= req_signed_i;
         op_size_p0   <= req_size_i;
         op_addr_p0   <= req_addr_i;
         op_wdata_p0  <= req_wdata_i;
      end
   end

   // p1: response captured from the alignment fault or the bus beat
   always_ff @(posedge cpu_clk_50M) begin
      if (take_bad) begin
         rsp_rdata_p1 <= '0;
         rsp_exc_p1   <= 1'b1;
         rsp_code_p1  <= req_store_i ? EXC_ADES : EXC_ADEL;
         rsp_bad_p1   <= req_addr_i;
      end else if (take_beat) begin
         if (dbus_rvalid_i && !dbus_err_i) begin
            rsp_rdata_p1 <= op_store_p0 ? '0 : ln_rdata_ext;
            rsp_exc_p1   <= 1'b0;
            rsp_code_p1  <= 5'd0;
            rsp_bad_p1   <= '0;
         end else begin
            rsp_rdata_p1 <= '0;
            rsp_exc_p1   <= 1'b1;
            rsp_code_p1  <= EXC_DBE;
            rsp_bad_p1   <= op_addr_p0;
         end
      end
   end

   assign req_ready_o     = in_idle;
   assign stall_o         = !in_idle || (req_valid_i && !flush_i);
   assign dbus_req_o      = (state_q == ST_REQ);
   assign dbus_we_o       = dbus_req_o && op_store_p0;
   assign dbus_be_o       = dbus_req_o ? ln_be : '0;
   assign dbus_addr_o     = dbus_req_o ? {op_addr_p0[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
   assign dbus_wdata_o    = dbus_req_o ? ln_wdata_rep : '0;
   assign resp_valid_o    = (state_q == ST_RESP);
   assign resp_rdata_o    = resp_valid_o ? rsp_rdata_p1 : '0;
   assign resp_exc_o      = resp_valid_o && rsp_exc_p1;
   assign resp_exccode_o  = resp_valid_o ? rsp_code_p1 : 5'd0;
   assign resp_badvaddr_o = resp_valid_o ? rsp_bad_p1 : '0;

endmodule

// File: tb/tb_mem_lsu_seq.sv
// Directed bench for mem_lsu_seq: a 32-bit and a 64-bit big-endian instance
// driven with hand-computed vectors; watchdog case only with MEM_LSU_TIMEOUT_EN.
module tb_mem_lsu_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic        a_flush, a_req_valid, a_req_ready, a_store, a_signed, a_stall;
   logic        a_dbus_req, a_gnt, a_we, a_rvalid, a_err, a_resp_valid, a_resp_ready, a_exc;
   logic [1:0]  a_size;
   logic [3:0]  a_be;
   logic [4:0]  a_code;
   logic [31:0] a_addr, a_wdata, a_dbus_addr, a_dbus_wdata, a_rdata, a_resp_rdata, a_bad;

   logic        b_flush, b_req_valid, b_req_ready, b_store, b_signed, b_stall;
   logic        b_dbus_req, b_gnt, b_we, b_rvalid, b_err, b_resp_valid, b_resp_ready, b_exc;
   logic [1:0]  b_size;
   logic [7:0]  b_be;
   logic [4:0]  b_code;
   logic [31:0] b_addr, b_dbus_addr, b_bad;
   logic [63:0] b_wdata, b_dbus_wdata, b_rdata, b_resp_rdata;

   mem_lsu_seq #(.DATA_W(32), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT_CYC(255)) u_dut32 (
      .cpu_clk_50M(clk), .cpu_rst(rst), .flush_i(a_flush),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_store_i(a_store),
      .req_size_i(a_size), .req_signed_i(a_signed), .req_addr_i(a_addr), .req_wdata_i(a_wdata),
      .stall_o(a_stall), .dbus_req_o(a_dbus_req), .dbus_gnt_i(a_gnt), .dbus_we_o(a_we),
      .dbus_be_o(a_be), .dbus_addr_o(a_dbus_addr), .dbus_wdata_o(a_dbus_wdata),
      .dbus_rvalid_i(a_rvalid), .dbus_rdata_i(a_rdata), .dbus_err_i(a_err),
      .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready), .resp_rdata_o(a_resp_rdata),
      .resp_exc_o(a_exc), .resp_exccode_o(a_code), .resp_badvaddr_o(a_bad)
   );

   mem_lsu_seq #(.DATA_W(64), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT_CYC(255)) u_dut64 (
      .cpu_clk_50M(clk), .cpu_rst(rst), .flush_i(b_flush),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_store_i(b_store),
      .req_size_i(b_size), .req_signed_i(b_signed), .req_addr_i(b_addr), .req_wdata_i(b_wdata),
      .stall_o(b_stall), .dbus_req_o(b_dbus_req), .dbus_gnt_i(b_gnt), .dbus_we_o(b_we),
      .dbus_be_o(b_be), .dbus_addr_o(b_dbus_addr), .dbus_wdata_o(b_dbus_wdata),
      .dbus_rvalid_i(b_rvalid), .dbus_rdata_i(b_rdata), .dbus_err_i(b_err),
      .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready), .resp_rdata_o(b_resp_rdata),
      .resp_exc_o(b_exc), .resp_exccode_o(b_code), .resp_badvaddr_o(b_bad)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Observations from the most recent op32 call
   logic        o_seen, o_we, o_stall, o_exc, o_after_valid, o_after_ready;
   logic [3:0]  o_be;
   logic [4:0]  o_code;
   logic [31:0] o_addr, o_wdata, o_rdata, o_bad;
   int          o_lat;

   // Issue one op on the 32-bit unit; gnt after gdly REQ cycles, rvalid the cycle after grant.
   task automatic op32(input logic st, input logic [1:0] sz, input logic sg,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input int gdly, input logic [31:0] rd, input logic er);
      int  cyc;
      int  wcnt;
      bit  granted;
      @(negedge clk);
      a_req_valid = 1'b1; a_store = st; a_size = sz; a_signed = sg; a_addr = ad; a_wdata = wd;
      #1;
      o_stall = a_stall & a_req_ready;
      @(negedge clk);
      a_req_valid = 1'b0;
      o_seen = 1'b0; o_be = '0; o_we = 1'b0; o_addr = '0; o_wdata = '0;
      cyc = 1; wcnt = 0; granted = 1'b0;
      while (!a_resp_valid && cyc < 40) begin
         if (!a_stall) o_stall = 1'b0;
         a_rvalid = 1'b0;
         if (granted) begin
            a_rvalid = 1'b1; a_rdata = rd; a_err = er; granted = 1'b0;
         end
         a_gnt = 1'b0;
         if (a_dbus_req) begin
            o_seen = 1'b1; o_be = a_be; o_we = a_we; o_addr = a_dbus_addr; o_wdata = a_dbus_wdata;
            if (wcnt == gdly) begin
               a_gnt = 1'b1; granted = 1'b1;
            end else begin
               wcnt++;
            end
         end
         @(negedge clk);
         cyc++;
      end
      a_rvalid = 1'b0; a_gnt = 1'b0; a_err = 1'b0;
      o_lat = cyc;
      if (!a_stall) o_stall = 1'b0;
      o_rdata = a_resp_rdata; o_exc = a_exc; o_code = a_code; o_bad = a_bad;
      a_resp_ready = 1'b1;
      @(negedge clk);
      a_resp_ready = 1'b0;
      o_after_valid = a_resp_valid;
      o_after_ready = a_req_ready;
   endtask

   initial begin
      bit ok;
      int waited;
      rst = 1'b1;
      a_flush = 0; a_req_valid = 0; a_store = 0; a_signed = 0; a_size = 0; a_addr = 0; a_wdata = 0;
      a_gnt = 0; a_rvalid = 0; a_err = 0; a_rdata = 0; a_resp_ready = 0;
      b_flush = 0; b_req_valid = 0; b_store = 0; b_signed = 0; b_size = 0; b_addr = 0; b_wdata = 0;
      b_gnt = 0; b_rvalid = 0; b_err = 0; b_rdata = 0; b_resp_ready = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", a_req_ready, 1'b1);
      check("rst_dbus_req", a_dbus_req, 1'b0);
      check("rst_resp_valid", a_resp_valid, 1'b0);
      check("rst_stall", a_stall, 1'b0);
      check("rst_be", a_be, 4'h0);

      // LW aligned
      op32(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, 32'h11223344, 1'b0);
      check("lw_seen", o_seen, 1'b1);
      check("lw_be", o_be, 4'hF);
      check("lw_addr", o_addr, 32'h100);
      check("lw_we", o_we, 1'b0);
      check("lw_lat", o_lat, 3);
      check("lw_stall", o_stall, 1'b1);
      check("lw_rdata", o_rdata, 32'h11223344);
      check("lw_exc", o_exc, 1'b0);
      check("lw_done_valid", o_after_valid, 1'b0);
      check("lw_done_ready", o_after_ready, 1'b1);

      // LB / LBU at the last byte of a word
      op32(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 0, 32'h000000F0, 1'b0);
      check("lb_be", o_be, 4'h1);
      check("lb_rdata", o_rdata, 32'hFFFFFFF0);
      op32(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h000000F0, 1'b0);
      check("lbu_rdata", o_rdata, 32'h000000F0);
      op32(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, 0, 32'hA5B6C7D8, 1'b0);
      check("lbu0_be", o_be, 4'h8);
      check("lbu0_rdata", o_rdata, 32'h000000A5);
      op32(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 0, 32'h80011234, 1'b0);
      check("lh_be", o_be, 4'hC);
      check("lh_rdata", o_rdata, 32'hFFFF8001);

      // Stores
      op32(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 0, 32'hDEADBEEF, 1'b0);
      check("sh_be", o_be, 4'h3);
      check("sh_wdata_lo", o_wdata[15:0], 16'hABCD);
      check("sh_we", o_we, 1'b1);
      check("sh_exc", o_exc, 1'b0);
      check("sh_rdata", o_rdata, 32'h0);
      op32(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000005A, 0, 32'h0, 1'b0);
      check("sb_be", o_be, 4'h4);
      check("sb_wdata_lane", o_wdata[23:16], 8'h5A);

      // Misaligned
      op32(1'b1, 2'd1, 1'b0, 32'h101, 32'h1234, 0, 32'h0, 1'b0);
      check("sh_mis_noreq", o_seen, 1'b0);
      check("sh_mis_exc", o_exc, 1'b1);
      check("sh_mis_code", o_code, 5'h05);
      check("sh_mis_bad", o_bad, 32'h101);
      check("sh_mis_lat", o_lat, 1);
      op32(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 0, 32'h0, 1'b0);
      check("lw_mis_code", o_code, 5'h04);
      op32(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 0, 32'h0, 1'b0);
      check("ld32_mis_code", o_code, 5'h04);

      // Bus error and delayed grant
      op32(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 0, 32'hCAFEF00D, 1'b1);
      check("dbe_exc", o_exc, 1'b1);
      check("dbe_code", o_code, 5'h07);
      check("dbe_bad", o_bad, 32'h200);
      op32(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 3, 32'h55AA55AA, 1'b0);
      check("slow_gnt_lat", o_lat, 6);
      check("slow_gnt_rdata", o_rdata, 32'h55AA55AA);

      // Flush in WAIT: beat completes, no response
      @(negedge clk);
      a_req_valid = 1'b1; a_store = 1'b0; a_size = 2'd2; a_addr = 32'h300;
      @(negedge clk);
      a_req_valid = 1'b0;
      ok = 1'b1;
      repeat (4) begin
         if (!a_dbus_req) ok = 1'b0;
         @(negedge clk);
      end
      check("fw_req_held", ok, 1'b1);
      a_gnt = 1'b1;
      @(negedge clk);
      a_gnt = 1'b0; a_flush = 1'b1;
      @(negedge clk);
      a_flush = 1'b0;
      check("fw_dbus_req", a_dbus_req, 1'b0);
      check("fw_busy", a_req_ready, 1'b0);
      a_rvalid = 1'b1; a_rdata = 32'h99999999;
      @(negedge clk);
      a_rvalid = 1'b0;
      check("fw_ready", a_req_ready, 1'b1);
      ok = 1'b1;
      repeat (3) begin
         if (a_resp_valid) ok = 1'b0;
         @(negedge clk);
      end
      check("fw_no_resp", ok, 1'b1);

      // Flush in RESP and flush against a new request in IDLE
      a_req_valid = 1'b1; a_store = 1'b1; a_size = 2'd1; a_addr = 32'h101;
      @(negedge clk);
      a_req_valid = 1'b0;
      check("fr_valid", a_resp_valid, 1'b1);
      a_flush = 1'b1;
      @(negedge clk);
      check("fr_cleared", a_resp_valid, 1'b0);
      a_req_valid = 1'b1; a_store = 1'b0; a_size = 2'd2; a_addr = 32'h100;
      #1;
      check("fi_stall", a_stall, 1'b0);
      @(negedge clk);
      a_req_valid = 1'b0; a_flush = 1'b0;
      check("fi_not_taken", a_dbus_req, 1'b0);

      // Reset in REQ
      a_req_valid = 1'b1; a_addr = 32'h500;
      @(negedge clk);
      a_req_valid = 1'b0;
      check("rr_in_req", a_dbus_req, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rr_dbus_req", a_dbus_req, 1'b0);
      check("rr_be", a_be, 4'h0);
      check("rr_addr", a_dbus_addr, 32'h0);
      check("rr_stall", a_stall, 1'b0);
      check("rr_ready", a_req_ready, 1'b1);
      a_rvalid = 1'b1; a_rdata = 32'h12345678;
      @(negedge clk);
      a_rvalid = 1'b0;
      check("rr_late_rvalid", a_resp_valid, 1'b0);

      // 64-bit instance
      b_req_valid = 1'b1; b_store = 1'b0; b_size = 2'd3; b_addr = 32'hC;
      @(negedge clk);
      b_req_valid = 1'b0;
      check("ld64_mis_valid", b_resp_valid, 1'b1);
      check("ld64_mis_code", b_code, 5'h04);
      check("ld64_mis_bad", b_bad, 32'hC);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      b_req_valid = 1'b1; b_addr = 32'h8;
      @(negedge clk);
      b_req_valid = 1'b0;
      check("ld64_be", b_be, 8'hFF);
      check("ld64_addr", b_dbus_addr, 32'h8);
      b_gnt = 1'b1;
      @(negedge clk);
      b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 64'h0123456789ABCDEF;
      @(negedge clk);
      b_rvalid = 1'b0;
      check("ld64_valid", b_resp_valid, 1'b1);
      check("ld64_rdata", b_resp_rdata, 64'h0123456789ABCDEF);
      b_resp_ready = 1'b1;
      @(negedge clk);
      b_resp_ready = 1'b0;
      b_req_valid = 1'b1; b_size = 2'd0; b_addr = 32'h9;
      @(negedge clk);
      b_req_valid = 1'b0;
      check("lb64_be", b_be, 8'h40);
      b_flush = 1'b1;
      @(negedge clk);
      b_flush = 1'b0;
      check("lb64_flush_req", b_dbus_req, 1'b0);
      check("lb64_flush_ready", b_req_ready, 1'b1);

`ifdef MEM_LSU_TIMEOUT_EN
      a_req_valid = 1'b1; a_store = 1'b0; a_size = 2'd2; a_addr = 32'h400;
      @(negedge clk);
      a_req_valid = 1'b0; a_gnt = 1'b1;
      @(negedge clk);
      a_gnt = 1'b0;
      waited = 0;
      while (!a_resp_valid && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check("to_fired", a_resp_valid, 1'b1);
      check("to_code", a_code, 5'h07);
      check("to_bad", a_bad, 32'h400);
      check("to_not_early", (waited >= 250), 1'b1);
      a_resp_ready = 1'b1;
      @(negedge clk);
      a_resp_ready = 1'b0;
`else
      waited = 0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
